// File: rtl/uart_frame_rx.sv
// Sync-hunting, length-prefixed frame receiver with additive checksum; replays verified payload.
// Optional: define UART_FRAME_STATS_EN to enable saturating good/dropped frame counters.
module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 32,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);
  localparam int             AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_L    = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t        state, state_n;
  logic [7:0]    len, sum, idx, rd_idx;
  logic [7:0]    mem [MAX_LEN];
  logic [TW-1:0] tmo;
  logic          acc, xfer, in_frame, tmo_hit, ok_set, err_set;
  logic [1:0]    code_n;
  logic [7:0]    sum_nx, len_last;

  assign in_ready  = (state != S_DRAIN);
  assign acc       = in_valid && in_ready;
  assign out_valid = (state == S_DRAIN);
  assign xfer      = out_valid && out_ready;
  assign len_last  = len - 8'd1;
  assign sum_nx    = sum + in_data;
  assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // An accepted byte always wins over a timeout landing in the same cycle.
  assign tmo_hit   = in_frame && !acc && (tmo == TMO_LAST);
  assign out_data  = out_valid ? mem[rd_idx[AW-1:0]] : 8'h00;
  assign out_last  = out_valid && (rd_idx == len_last);

  always_comb begin
    state_n = state;
    ok_set  = 1'b0;
    err_set = 1'b0;
    code_n  = 2'd0;
    case (state)
      S_HUNT: if (acc && in_data == SYNC_BYTE) state_n = S_LEN;
      S_LEN: begin
        if (acc) begin
          if (in_data == 8'd0 || in_data > MAX_L) begin
            err_set = 1'b1; code_n = 2'd1; state_n = S_HUNT;
          end else state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (acc && idx == len_last) state_n = S_CHK;
      S_CHK: begin
        if (acc) begin
          if (sum_nx == 8'h00) begin ok_set = 1'b1; state_n = S_DRAIN; end
          else begin err_set = 1'b1; code_n = 2'd2; state_n = S_HUNT; end
        end
      end
      S_DRAIN: if (xfer && rd_idx == len_last) state_n = S_HUNT;
      default: state_n = S_HUNT;
    endcase
    if (tmo_hit) begin
      err_set = 1'b1; code_n = 2'd3; state_n = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      len       <= 8'd0;
      sum       <= 8'd0;
      idx       <= 8'd0;
      rd_idx    <= 8'd0;
      tmo       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_n;
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) err_code <= code_n;
      if (acc || !in_frame) tmo <= '0;
      else                  tmo <= tmo + TW'(1);
      if (acc && state == S_LEN) begin
        len <= in_data;
        sum <= in_data;
        idx <= 8'd0;
      end
      if (acc && state == S_PAYLOAD) begin
        sum <= sum_nx;
        idx <= idx + 8'd1;
      end
      if (ok_set) rd_idx <= 8'd0;
      else if (xfer) rd_idx <= rd_idx + 8'd1;
    end
  end

  // Payload storage carries no reset; contents are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (acc && state == S_PAYLOAD) mem[idx[AW-1:0]] <= in_data;
  end

`ifdef UART_FRAME_STATS_EN
  logic [15:0] ok_q, err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q  <= 16'h0000;
      err_q <= 16'h0000;
    end else begin
      if (frame_ok  && ok_q  != 16'hFFFF) ok_q  <= ok_q  + 16'd1;
      if (frame_err && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end
  assign ok_cnt  = ok_q;
  assign err_cnt = err_q;
`else
  assign ok_cnt  = 16'h0000;
  assign err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_frame_rx;
  localparam int MAXL = 32;
  localparam int TMO  = 40;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready = 1'b1;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  uart_frame_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_q[$];   // {last, data}
  int ev_q[$];    // 0 = frame_ok, 1..3 = frame_err code
  int ok_exp = 0, err_exp = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Random downstream back-pressure, driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer or a frame pulse.
  bit stall = 0, prev_mid = 0, prev_last = 0;
  logic [7:0] pd;
  logic pl;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 0; prev_mid = 0; prev_last = 0;
    end else begin
      if (stall) chk("hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      if (prev_mid && out_ready) chk("no_bubble", out_valid, 1);
      if (prev_last) chk("post_last_idle", out_valid, 0);
      if (out_valid) chk("in_ready_low", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {out_last, out_data}, -1);
        else chk("out_byte", {out_last, out_data}, exp_q.pop_front());
      end
      if (frame_ok || frame_err) begin
        int got;
        got = frame_ok ? (frame_err ? 9 : 0) : int'(err_code);
        if (ev_q.size() == 0) chk("unexpected_event", got, -1);
        else chk("frame_event", got, ev_q.pop_front());
      end
      stall     = out_valid && !out_ready;
      prev_mid  = out_valid && out_ready && !out_last;
      prev_last = out_valid && out_ready && out_last;
      pd = out_data; pl = out_last;
    end
  end

  task automatic send(input logic [7:0] b);
    bit r;
    in_data = b; in_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin in_valid = 1'b0; return; end
    end
    chk("send_bound", 0, 1);
    in_valid = 1'b0;
  endtask

  // Frame-level model: outcome follows directly from length range and the mod-256 sum rule.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$], input logic [7:0] ck);
    int s;
    bit good;
    if (len == 0 || len > MAXL) begin
      ev_q.push_back(1); err_exp++;
      send(8'hA5); send(len);
      return;
    end
    s = len + ck;
    foreach (pay[i]) s += pay[i];
    good = (s % 256 == 0);
    if (good) begin
      ev_q.push_back(0); ok_exp++;
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) ? 1 : 0, pay[i]});
    end else begin
      ev_q.push_back(2); err_exp++;
    end
    send(8'hA5); send(len);
    for (int i = 0; i < len; i++) send(pay[i]);
    send(ck);
    if (good) chk("latency", out_valid, 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0 && ev_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (i == 5000) chk("drain_bound", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(string tag);
`ifdef UART_FRAME_STATS_EN
    chk({tag, "_ok_cnt"}, ok_cnt, ok_exp);
    chk({tag, "_err_cnt"}, err_cnt, err_exp);
`else
    chk({tag, "_ok_cnt"}, ok_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  initial begin
    logic [7:0] pay[$];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk_cnt("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic good frame
    pay = {8'h10, 8'h20, 8'h30};
    send_frame(8'd3, pay, 8'h9D);
    wait_idle(); chk_cnt("t1");

    // leading junk and a payload byte equal to the sync marker
    send(8'h00); send(8'hFF);
    pay = {8'hA5, 8'h11};
    send_frame(8'd2, pay, 8'h48);
    wait_idle();

    // bad checksum then good frame
    pay = {8'h10, 8'h20, 8'h30};
    send_frame(8'd3, pay, 8'h9C);
    send_frame(8'd3, pay, 8'h9D);
    wait_idle();

    // length out of range
    send_frame(8'h21, pay, 8'h00);
    send_frame(8'h00, pay, 8'h00);
    wait_idle();
    chk("t4_err_code_held", err_code, 1);

    // inter-byte timeout, then a fresh frame
    ev_q.push_back(3); err_exp++;
    send(8'hA5); send(8'h03); send(8'h10);
    repeat (TMO + 2) @(posedge clk);
    #1;
    chk("t5_in_ready", in_ready, 1);
    pay = {8'h10, 8'h20, 8'h30};
    send_frame(8'd3, pay, 8'h9D);
    wait_idle(); chk_cnt("t5");

    // output stall holds data and back-pressures input
    out_ready = 1'b0;
    send_frame(8'd3, pay, 8'h9D);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t6_stall_data", out_data, 8'h20);
      chk("t6_stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    // reset in the middle of a drain
    out_ready = 1'b0;
    send_frame(8'd3, pay, 8'h9D);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    exp_q.delete(); ev_q.delete();
    ok_exp = 0; err_exp = 0;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt("t6_rst");

    // randomized frames under random back-pressure
    rnd_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int kind, n, s;
      logic [7:0] len, ck, b;
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send(b);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
      end else begin
        case ($urandom_range(0, 5))
          0: len = 8'd1;
          1: len = 8'(MAXL);
          default: len = 8'($urandom_range(1, MAXL));
        endcase
      end
      pay.delete();
      s = len;
      for (int j = 0; j < len && kind != 0; j++) begin
        b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
        pay.push_back(b);
        s += b;
      end
      ck = 8'(256 - (s % 256));
      if (kind == 1 || kind == 2) ck = ck + 8'($urandom_range(1, 255));
      send_frame(len, pay, ck);
    end
    wait_idle();
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    chk_cnt("rand");
    chk("final_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
